// File: rtl/game_pkg.sv
// Shared types and constants for the game speed controller: speed levels,
// default terminal counts and lifecycle state encoding.
package game_pkg;

    typedef logic [1:0] level_t;

    localparam level_t LVL_SLOW    = 2'd0;
    localparam level_t LVL_NORMAL  = 2'd1;
    localparam level_t LVL_FAST    = 2'd2;
    localparam level_t LVL_EXTREME = 2'd3;

    // Default terminal counts; the tick period is TCn+1 clock cycles.
    localparam int TC0_DEFAULT = 3555555;
    localparam int TC1_DEFAULT = 1777777;
    localparam int TC2_DEFAULT = 888888;
    localparam int TC3_DEFAULT = 444444;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_RUN    = 2'd1;
    localparam state_t ST_PAUSED = 2'd2;

endpackage

// File: rtl/game_speed_controller_tick_counter.sv
// Programmable terminal-count counter with hold, synchronous clear and a
// registered one-cycle tick at the terminal count.
module tick_counter #(
    parameter int CNT_W = 22
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] tc,
    output logic             tick
);

    logic [CNT_W-1:0] count_reg;
    logic             tick_reg;

    always_ff @(posedge clkin) begin
        if (reset) begin
            count_reg <= '0;
            tick_reg  <= 1'b0;
        end else if (clr) begin
            count_reg <= '0;
            tick_reg  <= 1'b0;
        end else if (en) begin
            if (count_reg == tc) begin
                count_reg <= '0;
                tick_reg  <= 1'b1;
            end else begin
                count_reg <= count_reg + 1'b1;
                tick_reg  <= 1'b0;
            end
        end else begin
            // Disabled: hold the partial period so a resume continues it.
            tick_reg <= 1'b0;
        end
    end

    assign tick = tick_reg;

endmodule

// File: rtl/game_speed_controller.sv
// Game-step tick generator: run/pause/stop lifecycle, speed level with manual
// up/down and score-driven auto advance, and the per-level terminal-count mux.
module game_speed_controller
    import game_pkg::*;
#(
    parameter int TC0             = TC0_DEFAULT,
    parameter int TC1             = TC1_DEFAULT,
    parameter int TC2             = TC2_DEFAULT,
    parameter int TC3             = TC3_DEFAULT,
    parameter int CNT_W           = 22,
    parameter int SCORE_PER_LEVEL = 8,
    parameter int START_LEVEL     = 0
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic       level_up,
    input  logic       level_down,
    input  logic       score_event,
    output logic       tick,
    output logic [1:0] level,
    output logic       level_changed,
    output logic       running
);

    localparam int SCORE_W = $clog2(SCORE_PER_LEVEL + 1);

    state_t               state_reg, state_next;
    level_t               level_reg, level_next;
    logic [SCORE_W-1:0]   score_reg, score_next;
    logic                 running_reg;
    logic                 level_changed_reg;
    logic                 lvl_change;
    logic                 up_req, dn_req, score_ok, score_hit, want_up, want_dn;
    logic [CNT_W-1:0]     tc_sel;

    // Lifecycle: stop beats start beats pause.
    always_comb begin
        state_next = state_reg;
        if (stop) begin
            state_next = ST_IDLE;
        end else if (state_reg == ST_IDLE) begin
            if (start) state_next = ST_RUN;
        end else if (pause) begin
            state_next = (state_reg == ST_RUN) ? ST_PAUSED : ST_RUN;
        end
    end

    // A score threshold hit and a manual level_down cancel each other out.
    always_comb begin
        up_req     = level_up & ~level_down;
        dn_req     = level_down & ~level_up;
        score_ok   = score_event & (state_reg == ST_RUN);
        score_hit  = score_ok & (score_reg == SCORE_W'(SCORE_PER_LEVEL - 1));
        want_up    = up_req | (score_hit & ~dn_req);
        want_dn    = dn_req & ~score_hit;
        level_next = level_reg;
        lvl_change = 1'b0;
        if (want_up && level_reg != LVL_EXTREME) begin
            level_next = level_reg + 2'd1;
            lvl_change = 1'b1;
        end else if (want_dn && level_reg != LVL_SLOW) begin
            level_next = level_reg - 2'd1;
            lvl_change = 1'b1;
        end
        score_next = score_reg;
        if (score_ok) begin
            score_next = (up_req || score_hit) ? '0 : score_reg + 1'b1;
        end
    end

    always_comb begin
        case (level_reg)
            LVL_NORMAL:  tc_sel = CNT_W'(TC1);
            LVL_FAST:    tc_sel = CNT_W'(TC2);
            LVL_EXTREME: tc_sel = CNT_W'(TC3);
            default:     tc_sel = CNT_W'(TC0);
        endcase
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            state_reg         <= ST_IDLE;
            level_reg         <= level_t'(START_LEVEL);
            score_reg         <= '0;
            running_reg       <= 1'b0;
            level_changed_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            level_reg         <= level_next;
            score_reg         <= score_next;
            running_reg       <= (state_next == ST_RUN);
            level_changed_reg <= lvl_change;
        end
    end

    // Idle keeps the count at zero so entering RUN starts a clean period.
    tick_counter #(
        .CNT_W (CNT_W)
    ) u_tick_counter (
        .clkin (clkin),
        .reset (reset),
        .en    (state_reg == ST_RUN),
        .clr   (stop | lvl_change | (state_reg == ST_IDLE)),
        .tc    (tc_sel),
        .tick  (tick)
    );

    assign level         = level_reg;
    assign level_changed = level_changed_reg;
    assign running       = running_reg;

endmodule

// File: tb/tb_game_speed_controller.sv
// Bench for game_speed_controller: directed scenarios plus random pulses,
// all checked against a cycle-level reference model of the game rules.
module tb_game_speed_controller;

    localparam int TC0 = 7, TC1 = 3, TC2 = 1, TC3 = 0;
    localparam int SPL = 3, START = 0;

    logic       clkin = 1'b0;
    logic       reset = 1'b0, start = 1'b0, stop = 1'b0, pause = 1'b0;
    logic       level_up = 1'b0, level_down = 1'b0, score_event = 1'b0;
    logic       tick, level_changed, running;
    logic [1:0] level;

    int vectors = 0, miscompares = 0, cyc = 0;
    int tcv [4] = '{TC0, TC1, TC2, TC3};

    // Model: mode 0=idle 1=run 2=paused; phase = run cycles into the period.
    int m_mode = 0, m_phase = 0, m_level = START, m_score = 0;
    bit e_tick = 0, e_lc = 0, e_run = 0;

    always #5 clkin = ~clkin;

    game_speed_controller #(
        .TC0(TC0), .TC1(TC1), .TC2(TC2), .TC3(TC3),
        .CNT_W(22), .SCORE_PER_LEVEL(SPL), .START_LEVEL(START)
    ) dut (
        .clkin(clkin), .reset(reset), .start(start), .stop(stop), .pause(pause),
        .level_up(level_up), .level_down(level_down), .score_event(score_event),
        .tick(tick), .level(level), .level_changed(level_changed), .running(running)
    );

    function automatic void model_step();
        int nlvl, nmode, delta;
        bit up, dn, scored, hit, changed;
        if (reset) begin
            m_mode = 0; m_phase = 0; m_level = START; m_score = 0;
            e_tick = 0; e_lc = 0; e_run = 0;
            return;
        end
        up     = level_up && !level_down;
        dn     = level_down && !level_up;
        scored = score_event && (m_mode == 1);
        hit    = scored && (m_score + 1 == SPL);
        delta  = 0;
        if (up || (hit && !dn)) delta = 1;
        else if (dn && !hit)    delta = -1;
        nlvl = m_level + delta;
        if (nlvl > 3) nlvl = 3;
        if (nlvl < 0) nlvl = 0;
        changed = (nlvl != m_level);
        if (scored) m_score = (up || hit) ? 0 : m_score + 1;
        nmode = m_mode;
        if (stop)                          nmode = 0;
        else if (m_mode == 0 && start)     nmode = 1;
        else if (pause && m_mode == 1)     nmode = 2;
        else if (pause && m_mode == 2)     nmode = 1;
        e_tick = 0;
        if (stop || changed || m_mode == 0) begin
            m_phase = 0;
        end else if (m_mode == 1) begin
            m_phase++;
            if (m_phase == tcv[m_level] + 1) begin
                e_tick  = 1;
                m_phase = 0;
            end
        end
        m_level = nlvl;
        m_mode  = nmode;
        e_lc    = changed;
        e_run   = (nmode == 1);
    endfunction

    // Advance one clock with the currently driven pulses, then clear them.
    task automatic cycle();
        model_step();
        @(posedge clkin);
        #1;
        cyc++;
        {reset, start, stop, pause, level_up, level_down, score_event} = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; level_up = 1'b1;
        cycle();
        vectors++;
        if ({tick, level, level_changed, running} !== {1'b0, 2'(START), 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset cycle %0d: got t/l/c/r=%b/%0d/%b/%b want 0/%0d/0/0",
                     cyc, tick, level, level_changed, running, START);
        end
    endtask

    task automatic test_periodic();
        start = 1'b1;
        cycle();
        vectors++;
        if (running !== 1'b1 || tick !== 1'b0) begin
            miscompares++;
            $display("FAIL periodic_start cycle %0d: got run=%b tick=%b want run=1 tick=0", cyc, running, tick);
        end
        for (int n = 1; n <= 26; n++) begin
            cycle();
            vectors++;
            if (tick !== ((n % 8) == 0) || running !== 1'b1) begin
                miscompares++;
                $display("FAIL periodic n=%0d: got tick=%b run=%b want tick=%b run=1", n, tick, running, (n % 8) == 0);
            end
            vectors++;
            if ({tick, level, level_changed, running} !== {e_tick, 2'(m_level), e_lc, e_run}) begin
                miscompares++;
                $display("FAIL periodic_model cycle %0d: got %b/%0d/%b/%b want %b/%0d/%b/%b", cyc,
                         tick, level, level_changed, running, e_tick, m_level, e_lc, e_run);
            end
        end
    endtask

    task automatic test_pause();
        stop = 1'b1;  cycle();
        start = 1'b1; cycle();
        repeat (3) cycle();
        pause = 1'b1; cycle();
        for (int n = 0; n < 10; n++) begin
            cycle();
            vectors++;
            if (tick !== 1'b0 || running !== 1'b0) begin
                miscompares++;
                $display("FAIL paused n=%0d: got tick=%b run=%b want 0/0", n, tick, running);
            end
        end
        pause = 1'b1; cycle();
        for (int n = 1; n <= 4; n++) begin
            cycle();
            vectors++;
            if (tick !== (n == 4) || running !== 1'b1) begin
                miscompares++;
                $display("FAIL resume n=%0d: got tick=%b run=%b want tick=%b run=1", n, tick, running, n == 4);
            end
        end
    endtask

    task automatic test_level_up();
        stop = 1'b1;  cycle();
        start = 1'b1; cycle();
        for (int i = 0; i < 4; i++) begin
            level_up = 1'b1;
            cycle();
            vectors++;
            if (level !== 2'((i < 3) ? i + 1 : 3) || level_changed !== (i < 3)) begin
                miscompares++;
                $display("FAIL level_up i=%0d: got level=%0d lc=%b want level=%0d lc=%b",
                         i, level, level_changed, (i < 3) ? i + 1 : 3, i < 3);
            end
            cycle();
            vectors++;
            if (level_changed !== 1'b0) begin
                miscompares++;
                $display("FAIL level_up_gap i=%0d: got lc=%b want 0", i, level_changed);
            end
        end
        for (int n = 0; n < 5; n++) begin
            cycle();
            vectors++;
            if (tick !== 1'b1) begin
                miscompares++;
                $display("FAIL level3_tick n=%0d: got tick=%b want 1", n, tick);
            end
        end
    endtask

    task automatic test_score();
        stop = 1'b1; cycle();
        repeat (3) begin level_down = 1'b1; cycle(); end
        start = 1'b1; cycle();
        for (int i = 0; i < 6; i++) begin
            score_event = 1'b1;
            cycle();
            vectors++;
            if (level !== 2'((i + 1) / 3) || level_changed !== (((i + 1) % 3) == 0)) begin
                miscompares++;
                $display("FAIL score_run i=%0d: got level=%0d lc=%b want level=%0d lc=%b",
                         i, level, level_changed, (i + 1) / 3, ((i + 1) % 3) == 0);
            end
        end
        pause = 1'b1; cycle();
        for (int i = 0; i < 6; i++) begin
            score_event = 1'b1;
            cycle();
            vectors++;
            if (level !== 2'd2 || level_changed !== 1'b0) begin
                miscompares++;
                $display("FAIL score_paused i=%0d: got level=%0d lc=%b want 2/0", i, level, level_changed);
            end
        end
        pause = 1'b1; cycle();
        for (int i = 0; i < 3; i++) begin
            score_event = 1'b1;
            cycle();
            vectors++;
            if (level !== 2'((i == 2) ? 3 : 2)) begin
                miscompares++;
                $display("FAIL score_wrap i=%0d: got level=%0d want %0d", i, level, (i == 2) ? 3 : 2);
            end
        end
    endtask

    task automatic test_both_and_stop();
        level_up = 1'b1; level_down = 1'b1;
        cycle();
        vectors++;
        if (level !== 2'd3 || level_changed !== 1'b0) begin
            miscompares++;
            $display("FAIL up_down_both: got level=%0d lc=%b want 3/0", level, level_changed);
        end
        stop = 1'b1;
        cycle();
        vectors++;
        if (tick !== 1'b0 || running !== 1'b0 || level !== 2'd3) begin
            miscompares++;
            $display("FAIL stop_run: got tick=%b run=%b level=%0d want 0/0/3", tick, running, level);
        end
    endtask

    task automatic test_reset_mid();
        level_down = 1'b1; cycle();
        start = 1'b1;      cycle();
        cycle();
        reset = 1'b1;
        cycle();
        vectors++;
        if (level !== 2'(START) || tick !== 1'b0 || running !== 1'b0 || level_changed !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: got level=%0d tick=%b run=%b lc=%b want %0d/0/0/0",
                     level, tick, running, level_changed, START);
        end
        start = 1'b1; cycle();
        for (int n = 1; n <= 9; n++) begin
            cycle();
            vectors++;
            if (tick !== (n == 8)) begin
                miscompares++;
                $display("FAIL reset_restart n=%0d: got tick=%b want %b", n, tick, n == 8);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            reset       = ($urandom_range(0, 399) == 0);
            start       = ($urandom_range(0, 19) == 0);
            stop        = ($urandom_range(0, 59) == 0);
            pause       = ($urandom_range(0, 29) == 0);
            level_up    = ($urandom_range(0, 24) == 0);
            level_down  = ($urandom_range(0, 24) == 0);
            score_event = ($urandom_range(0, 5) == 0);
            cycle();
            vectors++;
            if ({tick, level, level_changed, running} !== {e_tick, 2'(m_level), e_lc, e_run}) begin
                miscompares++;
                $display("FAIL random cycle %0d: got t/l/c/r=%b/%0d/%b/%b want %b/%0d/%b/%b", cyc,
                         tick, level, level_changed, running, e_tick, m_level, e_lc, e_run);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_periodic();
        test_pause();
        test_level_up();
        test_score();
        test_both_and_stop();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
